// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: IFU PC register and fetch sequencer with one outstanding ibus request.
// Optional macro FETCH_STALL_CNT_EN adds a saturating fetch-stall cycle counter on stall_cnt_o.
module fetch_pc_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] pc_nxt_i,
    input  logic        redirect_valid,
    input  logic        flush,
    output logic [63:0] pc_o,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        ireq_ready,
    input  logic        iresp_valid,
    input  logic [31:0] iresp_data,
    output logic        out_valid,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        out_ready,
    output logic [63:0] stall_cnt_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      r_state;
    logic [63:0] r_pc;
    logic [63:0] r_addr;
    logic [63:0] r_out_pc;
    logic [31:0] r_out_instr;
    logic        r_drop;
    logic        w_kill;

    assign w_kill = redirect_valid | flush;

    // r_addr is latched on entry to REQ so a kill mid-request cannot retract the bus address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_addr      <= RESET_PC;
            r_out_pc    <= '0;
            r_out_instr <= '0;
            r_drop      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                    if (w_kill) begin
                        r_pc   <= pc_nxt_i;
                        r_addr <= pc_nxt_i;
                    end else begin
                        r_addr <= r_pc;
                    end
                end
                S_REQ: begin
                    if (w_kill) begin
                        r_pc   <= pc_nxt_i;
                        r_drop <= 1'b1;
                    end
                    if (ireq_ready) r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (iresp_valid) begin
                        if (r_drop || w_kill) begin
                            r_drop  <= 1'b0;
                            r_state <= S_REQ;
                            if (w_kill) begin
                                r_pc   <= pc_nxt_i;
                                r_addr <= pc_nxt_i;
                            end else begin
                                r_addr <= r_pc;
                            end
                        end else begin
                            r_out_instr <= iresp_data;
                            r_out_pc    <= r_pc;
                            r_state     <= S_HOLD;
                        end
                    end else if (w_kill) begin
                        r_pc   <= pc_nxt_i;
                        r_drop <= 1'b1;
                    end
                end
                S_HOLD: begin
                    // Handoff and held-instruction drop both advance to pc_nxt_i.
                    if (out_ready || w_kill) begin
                        r_pc    <= pc_nxt_i;
                        r_addr  <= pc_nxt_i;
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pc_o       = r_pc;
    assign ireq_valid = (r_state == S_REQ);
    assign ireq_addr  = r_addr;
    assign out_valid  = (r_state == S_HOLD);
    assign out_pc     = r_out_pc;
    assign out_instr  = r_out_instr;

`ifdef FETCH_STALL_CNT_EN
    logic [63:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = ((r_state == S_REQ) && !ireq_ready) ||
                     ((r_state == S_WAIT) && !iresp_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 64'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Randomized bench for fetch_pc_ctrl against a transaction-level model of the fetch sequence.
module tb_fetch_pc_ctrl;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] pc_nxt_i = '0;
    logic        redirect_valid = 1'b0;
    logic        flush = 1'b0;
    logic [63:0] pc_o;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        ireq_ready = 1'b0;
    logic        iresp_valid = 1'b0;
    logic [31:0] iresp_data = '0;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready = 1'b0;
    logic [63:0] stall_cnt_o;

    fetch_pc_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_nxt_i       (pc_nxt_i),
        .redirect_valid (redirect_valid),
        .flush          (flush),
        .pc_o           (pc_o),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .ireq_ready     (ireq_ready),
        .iresp_valid    (iresp_valid),
        .iresp_data     (iresp_data),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_ready      (out_ready),
        .stall_cnt_o    (stall_cnt_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: where fetching should be, and the life of the single in-flight request.
    logic [63:0] m_pc;
    logic [63:0] m_req_addr;
    logic [63:0] m_out_pc;
    logic [63:0] m_stall;
    bit          m_idle;
    bit          m_req_due;
    bit          m_req_open;
    bit          m_acc;
    bit          m_taint;
    bit          m_out_pending;
    int          resp_delay;

    int unsigned ready_pct;
    int unsigned ordy_pct;
    int unsigned kill_pct;
    int unsigned maxd;

    int          dut_hand = 0;
    logic [63:0] hand_pc[$];

    function automatic logic [31:0] imem(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ {a[15:0], a[31:16]} ^ 32'h5A3C_0F11;
    endfunction

    function automatic logic [63:0] pick_target();
        logic [63:0] t;
        case ($urandom_range(0, 3))
            0:       t = 64'h8000_0100;
            1:       t = 64'h8000_0200;
            2:       t = 64'hFFFF_FFFF_FFFF_FFF8;
            default: t = {$urandom, $urandom} & ~64'h3;
        endcase
        return t;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [63:0] exp_stall;
        if (m_req_due) begin
            m_req_open = 1'b1;
            m_acc      = 1'b0;
            m_taint    = 1'b0;
            m_req_addr = m_pc;
            m_req_due  = 1'b0;
        end
        check("ireq_valid", 64'(ireq_valid), 64'(m_req_open && !m_acc));
        if (m_req_open && !m_acc) check("ireq_addr", ireq_addr, m_req_addr);
        check("out_valid", 64'(out_valid), 64'(m_out_pending));
        if (m_out_pending) begin
            check("out_pc", out_pc, m_out_pc);
            check("out_instr", 64'(out_instr), 64'(imem(m_out_pc)));
        end
        check("pc_o", pc_o, m_pc);
`ifdef FETCH_STALL_CNT_EN
        exp_stall = m_stall;
`else
        exp_stall = '0;
`endif
        check("stall_cnt", stall_cnt_o, exp_stall);
    endtask

    task automatic drive_and_update();
        bit          kill;
        bit          rdy;
        bit          rv;
        bit          ordy;
        logic [63:0] nxt;
        kill = ($urandom_range(0, 99) < kill_pct);
        rdy  = ($urandom_range(0, 99) < ready_pct);
        ordy = ($urandom_range(0, 99) < ordy_pct);
        rv   = m_req_open && m_acc && (resp_delay == 0);
        redirect_valid = kill && ($urandom_range(0, 1) == 1);
        flush          = kill && !redirect_valid;
        ireq_ready     = rdy;
        out_ready      = ordy;
        iresp_valid    = rv;
        iresp_data     = rv ? imem(m_req_addr) : $urandom;
        if (kill)                       nxt = pick_target();
        else if (m_out_pending && ordy) nxt = m_out_pc + 64'd4;
        else                            nxt = {$urandom, $urandom};
        pc_nxt_i = nxt;

        if (out_valid && ordy) begin
            dut_hand++;
            hand_pc.push_back(out_pc);
        end

        if (m_idle) begin
            if (kill) m_pc = nxt;
            m_idle    = 1'b0;
            m_req_due = 1'b1;
        end else if (m_req_open && !m_acc) begin
            if (!rdy) m_stall++;
            if (kill) begin
                m_pc    = nxt;
                m_taint = 1'b1;
            end
            if (rdy) begin
                m_acc      = 1'b1;
                resp_delay = int'($urandom_range(0, maxd));
            end
        end else if (m_req_open && m_acc) begin
            if (rv) begin
                m_req_open = 1'b0;
                m_acc      = 1'b0;
                if (m_taint || kill) begin
                    if (kill) m_pc = nxt;
                    m_taint   = 1'b0;
                    m_req_due = 1'b1;
                end else begin
                    m_out_pending = 1'b1;
                    m_out_pc      = m_req_addr;
                end
            end else begin
                m_stall++;
                resp_delay--;
                if (kill) begin
                    m_pc    = nxt;
                    m_taint = 1'b1;
                end
            end
        end else if (m_out_pending) begin
            if (ordy || kill) begin
                m_out_pending = 1'b0;
                m_pc          = nxt;
                m_req_due     = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        drive_and_update();
        @(posedge clk);
    endtask

    task automatic reset_checks(input string phase);
        check({phase, "_ireq_valid"}, 64'(ireq_valid), 64'd0);
        check({phase, "_out_valid"}, 64'(out_valid), 64'd0);
        check({phase, "_pc_o"}, pc_o, RST_PC);
        check({phase, "_out_instr"}, 64'(out_instr), 64'd0);
        check({phase, "_stall"}, stall_cnt_o, 64'd0);
    endtask

    task automatic do_reset(input bit late_resp);
        @(negedge clk);
        rst_n          = 1'b0;
        iresp_valid    = 1'b1;
        iresp_data     = $urandom;
        redirect_valid = 1'b0;
        flush          = 1'b0;
        #1;
        reset_checks("rst_async");
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            reset_checks("rst_hold");
        end
        rst_n         = 1'b1;
        m_pc          = RST_PC;
        m_idle        = 1'b1;
        m_req_due     = 1'b0;
        m_req_open    = 1'b0;
        m_acc         = 1'b0;
        m_taint       = 1'b0;
        m_out_pending = 1'b0;
        m_stall       = '0;
        resp_delay    = 0;
        check_outputs();
        drive_and_update();
        if (late_resp) begin
            iresp_valid = 1'b1;
            iresp_data  = $urandom;
        end
        @(posedge clk);
    endtask

    initial begin
        // Streaming fetch: 3 cycles per instruction from RESET_PC upward.
        ready_pct = 100; ordy_pct = 100; kill_pct = 0; maxd = 0;
        do_reset(1'b0);
        repeat (30) cycle();
        check("stream_handoffs", 64'(dut_hand), 64'd10);
        if (hand_pc.size() >= 3) begin
            check("stream_pc0", hand_pc[0], 64'h8000_0000);
            check("stream_pc1", hand_pc[1], 64'h8000_0004);
            check("stream_pc2", hand_pc[2], 64'h8000_0008);
        end

        ready_pct = 60; ordy_pct = 70; kill_pct = 0; maxd = 2;
        repeat (300) cycle();

        ready_pct = 70; ordy_pct = 60; kill_pct = 15; maxd = 3;
        repeat (1500) cycle();

        ready_pct = 30; ordy_pct = 30; kill_pct = 5; maxd = 3;
        repeat (500) cycle();

        // Reset while a response is outstanding, with a late response on release.
        ready_pct = 100; ordy_pct = 100; kill_pct = 0; maxd = 3;
        for (int i = 0; i < 50 && !(m_req_open && m_acc); i++) cycle();
        do_reset(1'b1);

        ready_pct = 70; ordy_pct = 70; kill_pct = 10; maxd = 2;
        repeat (300) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
